// File: rtl/axi_m_port.sv
// ---------------------------------------------------------------------------
// axi_m_port -- N_M-master to single-slave AXI port multiplexer.
//
// Purpose:
//   Merges the AR, AW and W request channels of N_M masters onto one slave
//   port and routes the slave's R and B responses back to the master whose
//   index sits in the top bits of the response ID. Every channel is buffered
//   by a registered first-word-fall-through FIFO of DEPTH entries, so an item
//   accepted on one side appears on the other side one cycle later.
//
//   W beats are forwarded in AW-acceptance order: each granted AW pushes the
//   granted master index into a W-order queue, and only the master at the
//   queue head may present W beats. The head is retired on its WLAST beat.
//
// Configuration:
//   AXI_M_PORT_RR_EN  defined   -> round-robin arbitration on AR and AW,
//                                  pointer moves to granted index+1 on grant.
//                     undefined -> fixed priority, lowest master index wins.
//
// Ports:
//   AXI_CLK_i / AXI_RST_i            clock, asynchronous active-low reset
//   m_ar_* / m_aw_* / m_w_*          per-master request channels (packed,
//                                    master 0 in the LSBs), one-hot ready
//   s_ar_* / s_aw_* / s_w_*          merged request channels to the slave
//   s_r_* / s_b_*                    slave responses in
//   m_r_* / m_b_*                    routed responses: per-master valid,
//                                    broadcast data, per-master ready
//
// Handshake rule (all channels): a transfer happens in a cycle where valid
// and ready are both 1. Ready outputs here are combinational; valid outputs
// come straight from FIFO occupancy. Everything is held idle during reset.
// ---------------------------------------------------------------------------
module axi_m_port #(
  parameter int N_M   = 2,
  parameter int DEPTH = 4,
  parameter int ID_W  = 8,
  parameter int AR_W  = 49,
  parameter int W_W   = 37,
  parameter int R_W   = 43,
  parameter int B_W   = 10
) (
  input  logic                AXI_CLK_i,
  input  logic                AXI_RST_i,
  // master request side
  input  logic [N_M-1:0]      m_ar_valid_i,
  input  logic [N_M*AR_W-1:0] m_ar_data_i,
  output logic [N_M-1:0]      m_ar_ready_o,
  input  logic [N_M-1:0]      m_aw_valid_i,
  input  logic [N_M*AR_W-1:0] m_aw_data_i,
  output logic [N_M-1:0]      m_aw_ready_o,
  input  logic [N_M-1:0]      m_w_valid_i,
  input  logic [N_M*W_W-1:0]  m_w_data_i,
  output logic [N_M-1:0]      m_w_ready_o,
  // slave request side
  output logic                s_ar_valid_o,
  output logic [AR_W-1:0]     s_ar_data_o,
  input  logic                s_ar_ready_i,
  output logic                s_aw_valid_o,
  output logic [AR_W-1:0]     s_aw_data_o,
  input  logic                s_aw_ready_i,
  output logic                s_w_valid_o,
  output logic [W_W-1:0]      s_w_data_o,
  input  logic                s_w_ready_i,
  // slave response side
  input  logic                s_r_valid_i,
  input  logic [R_W-1:0]      s_r_data_i,
  output logic                s_r_ready_o,
  input  logic                s_b_valid_i,
  input  logic [B_W-1:0]      s_b_data_i,
  output logic                s_b_ready_o,
  // master response side
  output logic [N_M-1:0]      m_r_valid_o,
  output logic [R_W-1:0]      m_r_data_o,
  input  logic [N_M-1:0]      m_r_ready_i,
  output logic [N_M-1:0]      m_b_valid_o,
  output logic [B_W-1:0]      m_b_data_o,
  input  logic [N_M-1:0]      m_b_ready_i
);

  localparam int MI_W     = (N_M > 1) ? $clog2(N_M) : 1;
  // Master index = top MI_W bits of the ID, which itself sits in the MSBs.
  localparam int R_IDX_HI = (R_W - ID_W) + ID_W - 1;
  localparam int B_IDX_HI = (B_W - ID_W) + ID_W - 1;

  // Returns {found, index}: the first requesting master at or after 'start',
  // wrapping modulo N_M. Scanning backwards lets the lowest offset win.
  function automatic logic [MI_W:0] pick(input logic [N_M-1:0] req, input int start);
    logic [MI_W:0] res;
    int            k;
    res = '0;
    for (int i = N_M - 1; i >= 0; i--) begin
      k = (start + i) % N_M;
      if (req[k]) res = {1'b1, MI_W'(k)};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- AR path
  int              ar_start;
  logic [MI_W:0]   ar_pick;
  logic [MI_W-1:0] ar_idx;
  logic            ar_go;
  logic            ar_full;

  assign ar_pick      = pick(m_ar_valid_i, ar_start);
  assign ar_idx       = ar_pick[MI_W-1:0];
  assign ar_go        = ar_pick[MI_W] & ~ar_full & AXI_RST_i;
  assign m_ar_ready_o = ar_go ? (N_M'(1) << ar_idx) : '0;

  axi_m_port_fifo #(.W(AR_W), .DEPTH(DEPTH)) u_ar_fifo (
    .clk_i  (AXI_CLK_i),
    .rst_ni (AXI_RST_i),
    .push_i (ar_go),
    .data_i (m_ar_data_i[int'(ar_idx)*AR_W +: AR_W]),
    .pop_i  (s_ar_ready_i),
    .valid_o(s_ar_valid_o),
    .full_o (ar_full),
    .data_o (s_ar_data_o)
  );

  // ---------------------------------------------------------------- AW path
  int              aw_start;
  logic [MI_W:0]   aw_pick;
  logic [MI_W-1:0] aw_idx;
  logic            aw_go;
  logic            aw_full;
  logic            wq_full;

  assign aw_pick      = pick(m_aw_valid_i, aw_start);
  assign aw_idx       = aw_pick[MI_W-1:0];
  // An AW without room to record its W order would lose that order.
  assign aw_go        = aw_pick[MI_W] & ~aw_full & ~wq_full & AXI_RST_i;
  assign m_aw_ready_o = aw_go ? (N_M'(1) << aw_idx) : '0;

  axi_m_port_fifo #(.W(AR_W), .DEPTH(DEPTH)) u_aw_fifo (
    .clk_i  (AXI_CLK_i),
    .rst_ni (AXI_RST_i),
    .push_i (aw_go),
    .data_i (m_aw_data_i[int'(aw_idx)*AR_W +: AR_W]),
    .pop_i  (s_aw_ready_i),
    .valid_o(s_aw_valid_o),
    .full_o (aw_full),
    .data_o (s_aw_data_o)
  );

  // ------------------------------------------------------- arbitration mode
`ifdef AXI_M_PORT_RR_EN
  logic [MI_W-1:0] ar_ptr_q, ar_ptr_d;
  logic [MI_W-1:0] aw_ptr_q, aw_ptr_d;

  always_comb begin
    ar_ptr_d = ar_ptr_q;
    aw_ptr_d = aw_ptr_q;
    if (ar_go) ar_ptr_d = (int'(ar_idx) == N_M - 1) ? '0 : ar_idx + 1'b1;
    if (aw_go) aw_ptr_d = (int'(aw_idx) == N_M - 1) ? '0 : aw_idx + 1'b1;
  end

  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) begin
      ar_ptr_q <= '0;
      aw_ptr_q <= '0;
    end else begin
      ar_ptr_q <= ar_ptr_d;
      aw_ptr_q <= aw_ptr_d;
    end
  end

  assign ar_start = int'(ar_ptr_q);
  assign aw_start = int'(aw_ptr_q);
`else
  assign ar_start = 0;
  assign aw_start = 0;
`endif

  // ------------------------------------------------- W-order queue and W path
  logic            wq_valid;
  logic [MI_W-1:0] wq_head;
  logic            w_open;
  logic            w_acc;
  logic [W_W-1:0]  w_beat;
  logic            w_full;

  axi_m_port_fifo #(.W(MI_W), .DEPTH(DEPTH)) u_wq_fifo (
    .clk_i  (AXI_CLK_i),
    .rst_ni (AXI_RST_i),
    .push_i (aw_go),
    .data_i (aw_idx),
    .pop_i  (w_acc & w_beat[0]),
    .valid_o(wq_valid),
    .full_o (wq_full),
    .data_o (wq_head)
  );

  assign w_open      = wq_valid & ~w_full & AXI_RST_i;
  assign m_w_ready_o = w_open ? (N_M'(1) << wq_head) : '0;
  assign w_beat      = m_w_data_i[int'(wq_head)*W_W +: W_W];
  assign w_acc       = w_open & m_w_valid_i[wq_head];

  axi_m_port_fifo #(.W(W_W), .DEPTH(DEPTH)) u_w_fifo (
    .clk_i  (AXI_CLK_i),
    .rst_ni (AXI_RST_i),
    .push_i (w_acc),
    .data_i (w_beat),
    .pop_i  (s_w_ready_i),
    .valid_o(s_w_valid_o),
    .full_o (w_full),
    .data_o (s_w_data_o)
  );

  // ---------------------------------------------------------------- R path
  logic            r_full;
  logic            r_valid;
  logic [MI_W-1:0] r_idx;
  logic            r_idx_ok;
  logic            r_pop;

  assign s_r_ready_o = ~r_full & AXI_RST_i;
  assign r_idx       = m_r_data_o[R_IDX_HI -: MI_W];
  assign r_idx_ok    = int'(r_idx) < N_M;
  assign m_r_valid_o = (r_valid & r_idx_ok) ? (N_M'(1) << r_idx) : '0;
  // A head addressed to a non-existent master is dropped straight away.
  assign r_pop       = r_idx_ok ? m_r_ready_i[r_idx] : 1'b1;

  axi_m_port_fifo #(.W(R_W), .DEPTH(DEPTH)) u_r_fifo (
    .clk_i  (AXI_CLK_i),
    .rst_ni (AXI_RST_i),
    .push_i (s_r_valid_i & s_r_ready_o),
    .data_i (s_r_data_i),
    .pop_i  (r_pop),
    .valid_o(r_valid),
    .full_o (r_full),
    .data_o (m_r_data_o)
  );

  // ---------------------------------------------------------------- B path
  logic            b_full;
  logic            b_valid;
  logic [MI_W-1:0] b_idx;
  logic            b_idx_ok;
  logic            b_pop;

  assign s_b_ready_o = ~b_full & AXI_RST_i;
  assign b_idx       = m_b_data_o[B_IDX_HI -: MI_W];
  assign b_idx_ok    = int'(b_idx) < N_M;
  assign m_b_valid_o = (b_valid & b_idx_ok) ? (N_M'(1) << b_idx) : '0;
  assign b_pop       = b_idx_ok ? m_b_ready_i[b_idx] : 1'b1;

  axi_m_port_fifo #(.W(B_W), .DEPTH(DEPTH)) u_b_fifo (
    .clk_i  (AXI_CLK_i),
    .rst_ni (AXI_RST_i),
    .push_i (s_b_valid_i & s_b_ready_o),
    .data_i (s_b_data_i),
    .pop_i  (b_pop),
    .valid_o(b_valid),
    .full_o (b_full),
    .data_o (m_b_data_o)
  );

endmodule

// ---------------------------------------------------------------------------
// axi_m_port_fifo -- registered first-word-fall-through FIFO.
//   push_i/data_i  write side; a push while full is ignored (no bypass)
//   pop_i          consume the head; only acts while valid_o is 1
//   valid_o        !empty
//   full_o         DEPTH entries held
//   data_o         head entry, forced to 0 while empty
// Pointers carry one extra wrap bit to tell full from empty.
// ---------------------------------------------------------------------------
module axi_m_port_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, wr_d;
  logic [PW:0]  rd_q, rd_d;
  logic         empty;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty;
  assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: tb/tb_axi_m_port.sv
`timescale 1ns/1ps
module tb_axi_m_port;

  localparam int N_M   = 2;
  localparam int DEPTH = 4;
  localparam int ID_W  = 8;
  localparam int AR_W  = 49;
  localparam int W_W   = 37;
  localparam int R_W   = 43;
  localparam int B_W   = 10;

  // ------------------------------------------------------- clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------- DUT (N_M = 2)
  logic [N_M-1:0]      m_ar_valid, m_ar_ready, m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [N_M*AR_W-1:0] m_ar_data, m_aw_data;
  logic [N_M*W_W-1:0]  m_w_data;
  logic                s_ar_valid, s_ar_ready, s_aw_valid, s_aw_ready, s_w_valid, s_w_ready;
  logic [AR_W-1:0]     s_ar_data, s_aw_data;
  logic [W_W-1:0]      s_w_data;
  logic                s_r_valid, s_r_ready, s_b_valid, s_b_ready;
  logic [R_W-1:0]      s_r_data, m_r_data;
  logic [B_W-1:0]      s_b_data, m_b_data;
  logic [N_M-1:0]      m_r_valid, m_r_ready, m_b_valid, m_b_ready;

  axi_m_port #(.N_M(N_M), .DEPTH(DEPTH), .ID_W(ID_W), .AR_W(AR_W), .W_W(W_W),
               .R_W(R_W), .B_W(B_W)) dut (
    .AXI_CLK_i(clk), .AXI_RST_i(rst_n),
    .m_ar_valid_i(m_ar_valid), .m_ar_data_i(m_ar_data), .m_ar_ready_o(m_ar_ready),
    .m_aw_valid_i(m_aw_valid), .m_aw_data_i(m_aw_data), .m_aw_ready_o(m_aw_ready),
    .m_w_valid_i(m_w_valid), .m_w_data_i(m_w_data), .m_w_ready_o(m_w_ready),
    .s_ar_valid_o(s_ar_valid), .s_ar_data_o(s_ar_data), .s_ar_ready_i(s_ar_ready),
    .s_aw_valid_o(s_aw_valid), .s_aw_data_o(s_aw_data), .s_aw_ready_i(s_aw_ready),
    .s_w_valid_o(s_w_valid), .s_w_data_o(s_w_data), .s_w_ready_i(s_w_ready),
    .s_r_valid_i(s_r_valid), .s_r_data_i(s_r_data), .s_r_ready_o(s_r_ready),
    .s_b_valid_i(s_b_valid), .s_b_data_i(s_b_data), .s_b_ready_o(s_b_ready),
    .m_r_valid_o(m_r_valid), .m_r_data_o(m_r_data), .m_r_ready_i(m_r_ready),
    .m_b_valid_o(m_b_valid), .m_b_data_o(m_b_data), .m_b_ready_i(m_b_ready)
  );

  // ------------------------------------------------------- DUT (N_M = 3)
  logic [2:0]      t3_ar_valid, t3_ar_ready, t3_aw_valid, t3_aw_ready, t3_w_valid, t3_w_ready;
  logic [3*AR_W-1:0] t3_ar_data, t3_aw_data;
  logic [3*W_W-1:0]  t3_w_data;
  logic            t3_s_ar_valid, t3_s_aw_valid, t3_s_w_valid;
  logic [AR_W-1:0] t3_s_ar_data, t3_s_aw_data;
  logic [W_W-1:0]  t3_s_w_data;
  logic            t3_s_r_ready, t3_s_b_valid, t3_s_b_ready;
  logic [R_W-1:0]  t3_m_r_data;
  logic [B_W-1:0]  t3_s_b_data, t3_m_b_data;
  logic [2:0]      t3_m_r_valid, t3_m_r_ready, t3_m_b_valid, t3_m_b_ready;

  axi_m_port #(.N_M(3), .DEPTH(DEPTH), .ID_W(ID_W), .AR_W(AR_W), .W_W(W_W),
               .R_W(R_W), .B_W(B_W)) dut3 (
    .AXI_CLK_i(clk), .AXI_RST_i(rst_n),
    .m_ar_valid_i(t3_ar_valid), .m_ar_data_i(t3_ar_data), .m_ar_ready_o(t3_ar_ready),
    .m_aw_valid_i(t3_aw_valid), .m_aw_data_i(t3_aw_data), .m_aw_ready_o(t3_aw_ready),
    .m_w_valid_i(t3_w_valid), .m_w_data_i(t3_w_data), .m_w_ready_o(t3_w_ready),
    .s_ar_valid_o(t3_s_ar_valid), .s_ar_data_o(t3_s_ar_data), .s_ar_ready_i(1'b0),
    .s_aw_valid_o(t3_s_aw_valid), .s_aw_data_o(t3_s_aw_data), .s_aw_ready_i(1'b0),
    .s_w_valid_o(t3_s_w_valid), .s_w_data_o(t3_s_w_data), .s_w_ready_i(1'b0),
    .s_r_valid_i(1'b0), .s_r_data_i({R_W{1'b0}}), .s_r_ready_o(t3_s_r_ready),
    .s_b_valid_i(t3_s_b_valid), .s_b_data_i(t3_s_b_data), .s_b_ready_o(t3_s_b_ready),
    .m_r_valid_o(t3_m_r_valid), .m_r_data_o(t3_m_r_data), .m_r_ready_i(t3_m_r_ready),
    .m_b_valid_o(t3_m_b_valid), .m_b_data_o(t3_m_b_data), .m_b_ready_i(t3_m_b_ready)
  );

  // ------------------------------------------------------- scoreboard
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ------------------------------------------------------- payload helpers
  function automatic logic [AR_W-1:0] ar_pl(input int m, input int c);
    return AR_W'(64'h0A_0000_0000 + 64'(m) * 256 + 64'(c));
  endfunction

  function automatic logic [AR_W-1:0] aw_pl(input int c);
    return AR_W'(64'h1_0000_0000 + 64'(c));
  endfunction

  // Beat 2 of each burst carries WLAST in bit 0.
  function automatic logic [W_W-1:0] wbeat(input int m, input int b);
    return W_W'(((m + 1) * 64 + b) * 2 + ((b == 2) ? 1 : 0));
  endfunction

  function automatic logic [R_W-1:0] rp(input logic [ID_W-1:0] id, input int n);
    return {id, (R_W - ID_W)'(n)};
  endfunction

  // ------------------------------------------------------- R routing table
  typedef struct {
    logic           rv;
    logic [R_W-1:0] rd;
    logic [1:0]     rdy;
    logic [1:0]     exp_v;
    logic           exp_sr;
    logic           chk_d;
    logic [R_W-1:0] exp_d;
  } r_vec_t;

  localparam int NRV = 15;
  r_vec_t rv[NRV];

  function automatic r_vec_t mk(input logic v, input logic [R_W-1:0] d, input logic [1:0] rdy,
                                input logic [1:0] ev, input logic esr, input logic cd,
                                input logic [R_W-1:0] ed);
    r_vec_t r;
    r.rv = v; r.rd = d; r.rdy = rdy; r.exp_v = ev; r.exp_sr = esr; r.chk_d = cd; r.exp_d = ed;
    return r;
  endfunction

  // ------------------------------------------------------- driver tasks
  task automatic idle_inputs();
    m_ar_valid = '0; m_ar_data = '0; m_aw_valid = '0; m_aw_data = '0;
    m_w_valid = '0; m_w_data = '0;
    s_ar_ready = 1'b0; s_aw_ready = 1'b0; s_w_ready = 1'b0;
    s_r_valid = 1'b0; s_r_data = '0; s_b_valid = 1'b0; s_b_data = '0;
    m_r_ready = '0; m_b_ready = '0;
    t3_ar_valid = '0; t3_ar_data = '0; t3_aw_valid = '0; t3_aw_data = '0;
    t3_w_valid = '0; t3_w_data = '0; t3_s_b_valid = 1'b0; t3_s_b_data = '0;
    t3_m_r_ready = '0; t3_m_b_ready = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ------------------------------------------------------- test sequence
  initial begin
    int g, b0, b1;
    idle_inputs();

    // Reset: drive activity while reset is held; nothing may respond.
    m_ar_valid = 2'b11; m_aw_valid = 2'b11; m_w_valid = 2'b11;
    m_ar_data = {ar_pl(1, 9), ar_pl(0, 9)};
    s_r_valid = 1'b1; s_b_valid = 1'b1; s_ar_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_ar_ready", m_ar_ready, 0);
    chk("rst_aw_ready", m_aw_ready, 0);
    chk("rst_w_ready", m_w_ready, 0);
    chk("rst_s_r_ready", s_r_ready, 0);
    chk("rst_s_b_ready", s_b_ready, 0);
    @(negedge clk); #1;
    chk("rst_s_ar_valid", s_ar_valid, 0);
    chk("rst_s_ar_data", s_ar_data, 0);
    chk("rst_m_r_valid", m_r_valid, 0);
    chk("rst_m_b_valid", m_b_valid, 0);
    chk("rst_m_r_data", m_r_data, 0);
    reset_dut();

    // AR arbitration with both masters requesting and the slave always ready.
    s_ar_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 4) begin
        m_ar_valid = 2'b11;
        m_ar_data  = {ar_pl(1, c), ar_pl(0, c)};
      end else begin
        m_ar_valid = 2'b00;
      end
      #1;
      if (exp_q.size() > 0) begin
        chk("ar_out_valid", s_ar_valid, 1);
        chk("ar_out_data", s_ar_data, exp_q.pop_front());
      end
      if (c < 4) begin
`ifdef AXI_M_PORT_RR_EN
        g = c % 2;
`else
        g = 0;
`endif
        chk($sformatf("ar_grant_c%0d", c), m_ar_ready, 64'(1 << g));
        exp_q.push_back(64'(ar_pl(g, c)));
      end
    end
    @(negedge clk); #1;
    chk("ar_drained", s_ar_valid, 0);
    reset_dut();

    // AW fill with the slave stalled: 4 accepted, the 5th waits.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      m_aw_valid = 2'b01;
      m_aw_data  = {aw_pl(99), aw_pl(c)};
      #1;
      chk($sformatf("aw_fill_c%0d", c), m_aw_ready, (c < 4) ? 64'h1 : 64'h0);
      if (c < 4) exp_q.push_back(64'(aw_pl(c)));
    end
    chk("w_ready_head0", m_w_ready, 2'b01);
    @(negedge clk);
    s_aw_ready = 1'b1;
    #1;
    chk("aw_head_valid", s_aw_valid, 1);
    chk("aw_head_data", s_aw_data, exp_q.pop_front());
    chk("aw_full_stall", m_aw_ready, 0);
    // AW FIFO has room now but the W-order queue is still full.
    @(negedge clk);
    s_aw_ready = 1'b0;
    m_w_valid  = 2'b01;
    m_w_data   = {wbeat(1, 0), wbeat(0, 2)};
    #1;
    chk("w_last_ready", m_w_ready, 2'b01);
    chk("aw_wq_full_stall", m_aw_ready, 0);
    @(negedge clk);
    m_w_valid = 2'b00;
    #1;
    chk("aw_after_wq_pop", m_aw_ready, 2'b01);
    chk("w_out_valid", s_w_valid, 1);
    chk("w_out_data", s_w_data, wbeat(0, 2));
    // Reset with entries buffered: everything must be dropped.
    @(negedge clk);
    m_aw_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("midrst_aw_valid", s_aw_valid, 0);
    chk("midrst_w_valid", s_w_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("aw_flushed", s_aw_valid, 0);
    chk("wq_flushed", m_w_ready, 0);
    exp_q.delete();
    reset_dut();

    // W ordering: AW from master 1 then master 0; W beats must follow.
    s_aw_ready = 1'b1; s_w_ready = 1'b1;
    @(negedge clk);
    m_aw_valid = 2'b10;
    m_aw_data  = {aw_pl(11), aw_pl(10)};
    #1;
    chk("aw_m1_grant", m_aw_ready, 2'b10);
    @(negedge clk);
    m_aw_valid = 2'b01;
    #1;
    chk("aw_m0_grant", m_aw_ready, 2'b01);
    chk("aw_m1_out", s_aw_data, aw_pl(11));
    @(negedge clk);
    m_aw_valid = 2'b00;
    #1;
    chk("aw_m0_out", s_aw_data, aw_pl(10));
    for (int b = 0; b < 3; b++) exp_q.push_back(64'(wbeat(1, b)));
    for (int b = 0; b < 3; b++) exp_q.push_back(64'(wbeat(0, b)));
    b0 = 0; b1 = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      m_w_valid = {1'(b1 < 3), 1'(b0 < 3)};
      m_w_data  = {wbeat(1, b1), wbeat(0, b0)};
      #1;
      if (s_w_valid) begin
        if (exp_q.size() == 0) chk("w_extra_beat", 1, 0);
        else chk("w_order", s_w_data, exp_q.pop_front());
      end
      if (b1 < 3) chk("w_m0_blocked", m_w_ready[0], 0);
      if (m_w_ready[1] && m_w_valid[1]) b1++;
      if (m_w_ready[0] && m_w_valid[0]) b0++;
    end
    chk("w_all_beats", exp_q.size(), 0);
    chk("w_ready_idle", m_w_ready, 0);
    reset_dut();

    // R routing table.
    rv[0]  = mk(1, rp(8'h80, 1), 2'b00, 2'b00, 1, 0, '0);
    rv[1]  = mk(1, rp(8'h00, 2), 2'b00, 2'b10, 1, 1, rp(8'h80, 1));
    rv[2]  = mk(0, '0,           2'b01, 2'b10, 1, 1, rp(8'h80, 1));
    rv[3]  = mk(0, '0,           2'b10, 2'b10, 1, 1, rp(8'h80, 1));
    rv[4]  = mk(0, '0,           2'b10, 2'b01, 1, 1, rp(8'h00, 2));
    rv[5]  = mk(0, '0,           2'b01, 2'b01, 1, 1, rp(8'h00, 2));
    rv[6]  = mk(1, rp(8'h00, 3), 2'b00, 2'b00, 1, 0, '0);
    rv[7]  = mk(1, rp(8'h80, 4), 2'b00, 2'b01, 1, 1, rp(8'h00, 3));
    rv[8]  = mk(1, rp(8'h00, 5), 2'b00, 2'b01, 1, 0, '0);
    rv[9]  = mk(1, rp(8'h00, 6), 2'b00, 2'b01, 1, 0, '0);
    rv[10] = mk(0, '0,           2'b00, 2'b01, 0, 1, rp(8'h00, 3));
    rv[11] = mk(0, '0,           2'b01, 2'b01, 0, 0, '0);
    rv[12] = mk(0, '0,           2'b00, 2'b10, 1, 1, rp(8'h80, 4));
    rv[13] = mk(0, '0,           2'b10, 2'b10, 1, 0, '0);
    rv[14] = mk(0, '0,           2'b00, 2'b01, 1, 1, rp(8'h00, 5));
    for (int i = 0; i < NRV; i++) begin
      @(negedge clk);
      s_r_valid = rv[i].rv;
      s_r_data  = rv[i].rd;
      m_r_ready = rv[i].rdy;
      #1;
      chk($sformatf("r_valid_%0d", i), m_r_valid, rv[i].exp_v);
      chk($sformatf("r_sready_%0d", i), s_r_ready, rv[i].exp_sr);
      if (rv[i].chk_d) chk($sformatf("r_data_%0d", i), m_r_data, rv[i].exp_d);
    end
    reset_dut();

    // B routing on the two-master port.
    @(negedge clk);
    s_b_valid = 1'b1;
    s_b_data  = {8'h80, 2'b11};
    #1;
    chk("b_sready", s_b_ready, 1);
    chk("b_empty_valid", m_b_valid, 0);
    @(negedge clk);
    s_b_valid = 1'b0;
    #1;
    chk("b_m1_valid", m_b_valid, 2'b10);
    chk("b_m1_data", m_b_data, 10'h203);
    @(negedge clk);
    m_b_ready = 2'b10;
    #1;
    chk("b_m1_hold", m_b_valid, 2'b10);
    @(negedge clk);
    m_b_ready = 2'b00;
    #1;
    chk("b_popped", m_b_valid, 0);

    // Three-master port: ID index 3 is discarded, the next entry routes.
    @(negedge clk);
    t3_s_b_valid = 1'b1;
    t3_s_b_data  = {8'hC0, 2'b01};
    #1;
    chk("b3_sready", t3_s_b_ready, 1);
    @(negedge clk);
    t3_s_b_data = {8'h40, 2'b10};
    #1;
    chk("b3_bad_id_hidden", t3_m_b_valid, 3'b000);
    @(negedge clk);
    t3_s_b_valid = 1'b0;
    #1;
    chk("b3_next_valid", t3_m_b_valid, 3'b010);
    chk("b3_next_data", t3_m_b_data, 10'h102);
    @(negedge clk);
    t3_m_b_ready = 3'b010;
    #1;
    chk("b3_hold", t3_m_b_valid, 3'b010);
    @(negedge clk);
    t3_m_b_ready = 3'b000;
    #1;
    chk("b3_popped", t3_m_b_valid, 3'b000);

    // Final report.
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
